// File: rtl/clip_controller.sv
// clip_controller: IDLE/RECORD/PLAY sequencer for the 4-clip audio recorder.
// Turns synchronized button levels into single presses, runs the record and
// playback state machine, issues per-sample write/read strobes with a
// {clip, offset} address, and keeps the recorded length of each clip.
module clip_controller #(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              rst_btn,
    input  logic              rec_btn,
    input  logic              play_btn,
    input  logic [1:0]        clip_sel,
    output logic [ADDR_W+1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              recording,
    output logic              playing,
    output logic              done,
    output logic [3:0]        clip_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    // Length of a completely filled clip (DEPTH) and the last usable offset.
    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_OFF = '1;

    // Registered state
    logic [1:0]        state_q;
    logic [1:0]        cur_clip_q;
    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W:0]   len_q [4];
    logic              rst_prev_q;
    logic              rec_prev_q;
    logic              play_prev_q;

    // Next-state values
    logic [1:0]        state_d;
    logic [1:0]        cur_clip_d;
    logic [ADDR_W-1:0] offset_d;
    logic [ADDR_W:0]   len_d [4];
    logic [ADDR_W+1:0] addr_d;
    logic              we_d;
    logic              re_d;
    logic              done_d;

    // Single-cycle presses
    logic              rst_press;
    logic              rec_press;
    logic              play_press;

    // A press is the first cycle a level is seen high.
    always_comb begin
        rst_press  = rst_btn  & ~rst_prev_q;
        rec_press  = rec_btn  & ~rec_prev_q;
        play_press = play_btn & ~play_prev_q;
    end

    // A clip is playable whenever it holds at least one sample.
    always_comb begin
        clip_valid = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            clip_valid[i] = (len_q[i] != '0);
        end
    end

    // Sequencer: priority is clear > record > play > sample strobe.
    always_comb begin
        state_d    = state_q;
        cur_clip_d = cur_clip_q;
        offset_d   = offset_q;
        for (int unsigned i = 0; i < 4; i++) begin
            len_d[i] = len_q[i];
        end
        addr_d     = mem_addr;
        we_d       = 1'b0;
        re_d       = 1'b0;
        done_d     = 1'b0;

        if (rst_press) begin
            state_d = ST_IDLE;
            for (int unsigned i = 0; i < 4; i++) begin
                len_d[i] = '0;
            end
            done_d  = (state_q == ST_RECORD) || (state_q == ST_PLAY);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_press) begin
                        cur_clip_d      = clip_sel;
                        offset_d        = '0;
                        len_d[clip_sel] = '0;
                        state_d         = ST_RECORD;
                    end else if (play_press && (len_q[clip_sel] != '0)) begin
                        cur_clip_d = clip_sel;
                        offset_d   = '0;
                        state_d    = ST_PLAY;
                    end
                end

                ST_RECORD: begin
                    if (rec_press) begin
                        // Offset equals the number of samples already written.
                        len_d[cur_clip_q] = {1'b0, offset_q};
                        state_d           = ST_IDLE;
                        done_d            = 1'b1;
                    end else if (sample_en) begin
                        we_d     = 1'b1;
                        addr_d   = {cur_clip_q, offset_q};
                        offset_d = offset_q + ADDR_W'(1);
                        // The write at the last offset fills the clip; stop
                        // there so the offset wrap is never used.
                        if (offset_q == LAST_OFF) begin
                            len_d[cur_clip_q] = FULL_LEN;
                            state_d           = ST_IDLE;
                            done_d            = 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (play_press) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (sample_en) begin
                        re_d     = 1'b1;
                        addr_d   = {cur_clip_q, offset_q};
                        offset_d = offset_q + ADDR_W'(1);
                        if ({1'b0, offset_q} == (len_q[cur_clip_q] - (ADDR_W+1)'(1))) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Button history for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_prev_q  <= 1'b0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
        end else begin
            rst_prev_q  <= rst_btn;
            rec_prev_q  <= rec_btn;
            play_prev_q <= play_btn;
        end
    end

    // Sequencer state, clip lengths and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_clip_q <= '0;
            offset_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                len_q[i] <= '0;
            end
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            recording  <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_clip_q <= cur_clip_d;
            offset_q   <= offset_d;
            for (int unsigned i = 0; i < 4; i++) begin
                len_q[i] <= len_d[i];
            end
            mem_addr   <= addr_d;
            mem_we     <= we_d;
            mem_re     <= re_d;
            // Decoded from the next state so the flags track state_q exactly.
            recording  <= (state_d == ST_RECORD);
            playing    <= (state_d == ST_PLAY);
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_clip_controller.sv
// tb_clip_controller: directed table-driven bench for clip_controller with
// ADDR_W=3 (8-sample clips, 5-bit memory address).
module tb_clip_controller;

    logic       clock;
    logic       reset;
    logic       sample_en;
    logic       rst_btn;
    logic       rec_btn;
    logic       play_btn;
    logic [1:0] clip_sel;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic       mem_re;
    logic       recording;
    logic       playing;
    logic       done;
    logic [3:0] clip_valid;

    int tests;
    int failed;

    typedef struct {
        logic       rst;
        logic       rec;
        logic       play;
        logic       se;
        logic [1:0] sel;
        logic [4:0] addr;
        logic       we;
        logic       re;
        logic       recd;
        logic       pl;
        logic       dn;
        logic [3:0] valid;
    } vec_t;

    vec_t tbl[$];

    clip_controller #(.ADDR_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_en  (sample_en),
        .rst_btn    (rst_btn),
        .rec_btn    (rec_btn),
        .play_btn   (play_btn),
        .clip_sel   (clip_sel),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .recording  (recording),
        .playing    (playing),
        .done       (done),
        .clip_valid (clip_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic rst, logic rec, logic play, logic se, logic [1:0] sel,
                                logic [4:0] addr, logic we, logic re, logic recd, logic pl,
                                logic dn, logic [3:0] valid);
        vec_t v;
        v.rst = rst; v.rec = rec; v.play = play; v.se = se; v.sel = sel;
        v.addr = addr; v.we = we; v.re = re; v.recd = recd; v.pl = pl;
        v.dn = dn; v.valid = valid;
        return v;
    endfunction

    // Compare {addr, we, re, recording, playing, done, clip_valid}.
    task automatic chk(input string name, input logic [4:0] addr, input logic we, input logic re,
                       input logic recd, input logic pl, input logic dn, input logic [3:0] valid);
        logic [13:0] exp_v;
        logic [13:0] act_v;
        exp_v = {addr, we, re, recd, pl, dn, valid};
        act_v = {mem_addr, mem_we, mem_re, recording, playing, done, clip_valid};
        tests++;
        if (act_v !== exp_v) begin
            failed++;
            $display("FAIL %s: got addr=%b we=%b re=%b rec=%b play=%b done=%b valid=%b, expected addr=%b we=%b re=%b rec=%b play=%b done=%b valid=%b",
                     name, mem_addr, mem_we, mem_re, recording, playing, done, clip_valid,
                     addr, we, re, recd, pl, dn, valid);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1ns later.
    task automatic step(input logic rst, input logic rec, input logic play, input logic se,
                        input logic [1:0] sel);
        @(negedge clock);
        rst_btn   = rst;
        rec_btn   = rec;
        play_btn  = play;
        sample_en = se;
        clip_sel  = sel;
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b0;
        sample_en = 1'b0;
        rst_btn   = 1'b0;
        rec_btn   = 1'b0;
        play_btn  = 1'b0;
        clip_sel  = 2'd0;

        //           rst rec ply se sel   addr     we re rec ply dn valid
        // Record clip 2: three samples, then stop.
        tbl.push_back(mk(0, 1, 0, 0, 2, 5'd0,  0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd16, 1, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 2, 5'd16, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd17, 1, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd18, 1, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 0, 2, 5'd18, 0, 0, 0, 0, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 0, 2, 5'd18, 0, 0, 0, 0, 0, 4'b0100));
        // Play clip 2 with five strobes: reads 16..18 only, done on third.
        tbl.push_back(mk(0, 0, 1, 0, 2, 5'd18, 0, 0, 0, 1, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd16, 0, 1, 0, 1, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd17, 0, 1, 0, 1, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd18, 0, 1, 0, 0, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd18, 0, 0, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5'd18, 0, 0, 0, 0, 0, 4'b0100));
        // Play on empty clip 0 is ignored.
        tbl.push_back(mk(0, 0, 1, 0, 0, 5'd18, 0, 0, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'd18, 0, 0, 0, 0, 0, 4'b0100));
        // rec+play together from IDLE -> RECORD clip 1, then fill all 8.
        tbl.push_back(mk(0, 1, 1, 0, 1, 5'd18, 0, 0, 1, 0, 0, 4'b0100));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 0, 0, 1, 1, 5'(8 + k), 1, 0, 1, 0, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5'd15, 1, 0, 0, 0, 1, 4'b0110));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5'd15, 0, 0, 0, 0, 0, 4'b0110));
        // Held play button gives one start; a fresh press stops playback.
        tbl.push_back(mk(0, 0, 1, 1, 1, 5'd15, 0, 0, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 0, 1, 1, 1, 5'd8,  0, 1, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 0, 1, 1, 1, 5'd9,  0, 1, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 0, 1, 0, 1, 5'd9,  0, 0, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd9,  0, 0, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 0, 1, 1, 1, 5'd9,  0, 0, 0, 0, 1, 4'b0110));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd9,  0, 0, 0, 0, 0, 4'b0110));
        // Play clip 2, rec press ignored, then clear during PLAY.
        tbl.push_back(mk(0, 0, 1, 0, 2, 5'd9,  0, 0, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(0, 1, 0, 1, 2, 5'd16, 0, 1, 0, 1, 0, 4'b0110));
        tbl.push_back(mk(1, 0, 0, 0, 2, 5'd16, 0, 0, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 2, 5'd16, 0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 0, 1, 5'd16, 0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd16, 0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 0, 2, 5'd16, 0, 0, 0, 0, 0, 4'b0000));
        // Record clip 3; play press and clip_sel change ignored; rec+sample stop wins.
        tbl.push_back(mk(0, 1, 0, 0, 3, 5'd16, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 1, 0, 5'd24, 1, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 1, 0, 5'd24, 0, 0, 0, 0, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd24, 0, 0, 0, 0, 0, 4'b1000));
        // Record clip 0 and stop with no samples: clip stays invalid.
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'd24, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd24, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'd24, 0, 0, 0, 0, 1, 4'b1000));
        // Clear from IDLE: lengths cleared, no done pulse.
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'd24, 0, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd24, 0, 0, 0, 0, 0, 4'b0000));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", 5'd0, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rec, tbl[i].play, tbl[i].se, tbl[i].sel);
            chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].re,
                tbl[i].recd, tbl[i].pl, tbl[i].dn, tbl[i].valid);
        end

        // Asynchronous reset in the middle of RECORD with a sample pending.
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("pre_rst_write", 5'd8, 1, 0, 1, 0, 0, 4'b0000);
        step(0, 1, 0, 0, 1);
        chk("pre_rst_stop", 5'd8, 0, 0, 0, 0, 1, 4'b0010);
        step(0, 0, 0, 0, 2);
        step(0, 1, 0, 0, 2);
        chk("pre_rst_rec", 5'd8, 0, 0, 1, 0, 0, 4'b0010);
        @(negedge clock);
        rec_btn   = 1'b0;
        sample_en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_now", 5'd0, 0, 0, 0, 0, 0, 4'b0000);
        @(posedge clock);
        #1;
        chk("async_rst_held", 5'd0, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_no_strobe", 5'd0, 0, 0, 0, 0, 0, 4'b0000);
        step(0, 0, 0, 1, 2);
        chk("post_rst_idle", 5'd0, 0, 0, 0, 0, 0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clip_controller.md
Name: clip_controller

Overview:
- Sequencer for the 4-clip audio recorder: consumes the synchronized button and switch levels and drives the clip storage memory.
- Detects button presses and runs an IDLE/RECORD/PLAY state machine.
- Generates per-sample write/read strobes and addresses, and holds the recorded length of each clip.
- Sits between the synchronizer outputs and the clip RAM; the sample-rate strobe comes from the sample timer.

Parameters:
- ADDR_W, 14, offset bits per clip; clip depth DEPTH = 2^ADDR_W samples.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low system reset.
- sample_en  in  1  one-cycle sample-rate strobe.
- rst_btn  in  1  synchronized clear button, active-high level.
- rec_btn  in  1  synchronized record button, active-high level.
- play_btn  in  1  synchronized play button, active-high level.
- clip_sel  in  2  synchronized clip switches {switch1, switch0}.
- mem_addr  out  ADDR_W+2  {clip, offset} address to clip RAM.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- recording  out  1  high while in RECORD.
- playing  out  1  high while in PLAY.
- done  out  1  one-cycle pulse when RECORD or PLAY ends for any reason.
- clip_valid  out  4  bit i = 1 when len[i] != 0.

Behaviour:
- Reset (reset=0, asynchronous) clears all state and outputs:
  - state=IDLE; mem_addr=0; mem_we=mem_re=recording=playing=done=0.
  - All len[i]=0; edge-detect registers=0.
- Edge detection: register each button once per cycle; a press is level=1 AND previous=0. Held buttons produce exactly one press.
- Internal state:
  - cur_clip: 2-bit latch.
  - offset: ADDR_W-bit counter.
  - len[0..3]: ADDR_W+1 bits each, range 0..DEPTH.
- Priority per cycle: rst press > rec press > play press > sample_en.
- rst press in any state:
  - Go to IDLE and clear all len[i].
  - No mem strobe that cycle.
  - done=1 next cycle only if the previous state was RECORD or PLAY.
- IDLE, rec press:
  - cur_clip <= clip_sel, offset <= 0, len[clip_sel] <= 0.
  - Go to RECORD.
- IDLE, play press (no rec press):
  - If len[clip_sel] != 0: cur_clip <= clip_sel, offset <= 0, go to PLAY.
  - Otherwise ignore the press and stay in IDLE.
- RECORD, sample_en:
  - Next cycle mem_we=1 with mem_addr={cur_clip,offset}; offset increments.
  - Write latency is 1 cycle from sample_en.
- RECORD, full: on the write at offset=DEPTH-1, set len[cur_clip]=DEPTH, go to IDLE, done=1 in that same output cycle. The offset wrap is never used.
- RECORD, rec press:
  - Stop with len[cur_clip]=offset (number of samples written), go to IDLE, done=1 next cycle.
  - If a rec press and sample_en coincide, the stop wins and no write occurs.
  - Stopping with offset=0 gives len=0, so the clip is invalid.
- RECORD ignores play presses.
- PLAY, sample_en: next cycle mem_re=1 with mem_addr={cur_clip,offset}; offset increments.
- PLAY, end: on the read at offset=len[cur_clip]-1, go to IDLE with done=1 in the same output cycle.
- PLAY, play press: stop immediately, done=1 next cycle; a coincident sample_en is dropped.
- PLAY ignores rec presses.
- clip_sel changes during RECORD/PLAY have no effect; only cur_clip is used.
- Outputs:
  - mem_we, mem_re and done are at most one cycle wide.
  - recording and playing are registered decodes of state.
  - mem_addr holds its last value between strobes.

Test Plan:
- Reset: assert reset=0 mid-RECORD with a sample_en pending -> all outputs 0 immediately, clip_valid=0000, no strobe after release.
- Record clip 2, ADDR_W=3: clip_sel=10, rec press, 3 sample_en, then rec press -> mem_we at addr 10000, 10001, 10010; done pulse; clip_valid=0100.
- Full record clip 1, ADDR_W=3: 8 sample_en -> last write addr 01111, auto return to IDLE with done, len[1]=8; a 9th sample_en gives no strobe.
- Playback clip 2: play press then 5 sample_en -> mem_re at 10000..10010 only, done on the third read, playing=0 afterwards.
- Empty/collision cases:
  - Play press on clip 0 with len=0 -> stays IDLE, no strobes.
  - rec and play pressed in the same cycle from IDLE -> RECORD.
  - Button held 10 cycles -> single start.
- Clear: rst press during PLAY -> IDLE, done pulse, clip_valid=0000; a later play press on any clip is ignored.
